// File: rtl/setup_loader_if.sv
// Byte-stream and core setup-port signals of the program loader.
// The byte source holds the master side. The loader holds the slave side.
interface setup_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        abort;
    logic        setup_write;
    logic [31:0] setup_address;
    logic [31:0] setup_data_in;
    logic        core_hold;
    logic        done;
    logic        error;

    modport master (
        output in_valid, in_data, abort,
        input  in_ready, setup_write, setup_address, setup_data_in,
               core_hold, done, error
    );

    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, setup_write, setup_address, setup_data_in,
               core_hold, done, error
    );
endinterface

// File: rtl/setup_loader.sv
// Byte-stream program loader.
// A frame has this layout: MAGIC, 4 address bytes (little-endian), 2 count bytes (LE),
// count x 4 data bytes (LE words), and 1 checksum byte.
// The loader writes one 32-bit word into the core's setup port each time a word completes.
// It keeps the core held in reset until a frame ends with a good checksum.
module setup_loader #(
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter int unsigned MAX_WORDS = 65535
) (
    input  logic         clock,
    input  logic         reset,
    setup_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_next;
    logic [1:0]  byte_idx, byte_idx_next;
    logic [15:0] word_cnt, word_cnt_next;
    logic [7:0]  cnt_lo, cnt_lo_next;
    logic [31:0] addr, addr_next;
    logic [23:0] word_buf, word_buf_next;
    logic [7:0]  sum, sum_next;

    logic        setup_write_q, setup_write_next;
    logic [31:0] setup_address_q, setup_address_next;
    logic [31:0] setup_data_q, setup_data_next;
    logic        core_hold_q, core_hold_next;
    logic        done_q, done_next;
    logic        error_q, error_next;
    logic        in_ready_q;

    logic        accept;
    logic [7:0]  in_byte;
    logic [15:0] cnt_full;

    assign in_byte  = bus.in_data;
    assign accept   = bus.in_valid && in_ready_q;
    assign cnt_full = {in_byte, cnt_lo};

    assign bus.in_ready      = in_ready_q;
    assign bus.setup_write   = setup_write_q;
    assign bus.setup_address = setup_address_q;
    assign bus.setup_data_in = setup_data_q;
    assign bus.core_hold     = core_hold_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;

    // This block computes the next frame-parser state and the next values of all outputs.
    // Abort takes priority over a byte that arrives in the same cycle.
    always_comb begin
        state_next         = state;
        byte_idx_next      = byte_idx;
        word_cnt_next      = word_cnt;
        cnt_lo_next        = cnt_lo;
        addr_next          = addr;
        word_buf_next      = word_buf;
        sum_next           = sum;
        setup_write_next   = 1'b0;
        setup_address_next = setup_address_q;
        setup_data_next    = setup_data_q;
        core_hold_next     = core_hold_q;
        done_next          = done_q;
        error_next         = error_q;

        if (bus.abort) begin
            state_next     = S_IDLE;
            byte_idx_next  = 2'd0;
            core_hold_next = 1'b1;
            done_next      = 1'b0;
            error_next     = 1'b0;
        end else if (accept) begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (in_byte == MAGIC) begin
                        state_next     = S_ADDR;
                        byte_idx_next  = 2'd0;
                        sum_next       = 8'd0;
                        done_next      = 1'b0;
                        error_next     = 1'b0;
                        core_hold_next = 1'b1;
                    end
                end
                S_ADDR: begin
                    sum_next      = sum + in_byte;
                    byte_idx_next = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: addr_next[7:0]   = in_byte;
                        2'd1: addr_next[15:8]  = in_byte;
                        2'd2: addr_next[23:16] = in_byte;
                        default: begin
                            addr_next[31:24] = in_byte;
                            addr_next[1:0]   = 2'b00;
                            state_next       = S_COUNT;
                        end
                    endcase
                end
                S_COUNT: begin
                    sum_next = sum + in_byte;
                    if (byte_idx == 2'd0) begin
                        cnt_lo_next   = in_byte;
                        byte_idx_next = 2'd1;
                    end else begin
                        byte_idx_next = 2'd0;
                        word_cnt_next = cnt_full;
                        if (cnt_full == 16'd0) begin
                            state_next = S_CHECK;
                        end else if ({16'd0, cnt_full} > MAX_WORDS) begin
                            state_next     = S_ERR;
                            error_next     = 1'b1;
                            done_next      = 1'b0;
                            core_hold_next = 1'b1;
                        end else begin
                            state_next = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    sum_next      = sum + in_byte;
                    byte_idx_next = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_buf_next[7:0]   = in_byte;
                        2'd1: word_buf_next[15:8]  = in_byte;
                        2'd2: word_buf_next[23:16] = in_byte;
                        default: begin
                            setup_write_next   = 1'b1;
                            setup_address_next = addr;
                            setup_data_next    = {in_byte, word_buf};
                            addr_next          = addr + 32'd4;
                            word_cnt_next      = word_cnt - 16'd1;
                            if (word_cnt == 16'd1) begin
                                state_next = S_CHECK;
                            end
                        end
                    endcase
                end
                S_CHECK: begin
                    if (in_byte == sum) begin
                        state_next     = S_DONE;
                        done_next      = 1'b1;
                        error_next     = 1'b0;
                        core_hold_next = 1'b0;
                    end else begin
                        state_next     = S_ERR;
                        done_next      = 1'b0;
                        error_next     = 1'b1;
                        core_hold_next = 1'b1;
                    end
                end
                default: begin
                    state_next    = S_IDLE;
                    byte_idx_next = 2'd0;
                end
            endcase
        end
    end

    // This block registers the parser state, the datapath, and every output.
    // Reset discards any partial word, so the loader never issues a write for it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            byte_idx        <= 2'd0;
            word_cnt        <= 16'd0;
            cnt_lo          <= 8'd0;
            addr            <= 32'd0;
            word_buf        <= 24'd0;
            sum             <= 8'd0;
            setup_write_q   <= 1'b0;
            setup_address_q <= 32'd0;
            setup_data_q    <= 32'd0;
            core_hold_q     <= 1'b1;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state           <= state_next;
            byte_idx        <= byte_idx_next;
            word_cnt        <= word_cnt_next;
            cnt_lo          <= cnt_lo_next;
            addr            <= addr_next;
            word_buf        <= word_buf_next;
            sum             <= sum_next;
            setup_write_q   <= setup_write_next;
            setup_address_q <= setup_address_next;
            setup_data_q    <= setup_data_next;
            core_hold_q     <= core_hold_next;
            done_q          <= done_next;
            error_q         <= error_next;
        end
    end

    // The loader accepts a byte in every cycle except while reset is asserted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
        end
    end

endmodule
